// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter: FSM state encoding,
// default parameter values and the error-response pattern.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam int DEF_NREQ    = 3;
  localparam int DEF_MSG_W   = 32;
  localparam int DEF_TIMEOUT = 255;

  // Wide enough for any supported MSG_W; truncated at the point of use.
  localparam logic [63:0] ERR_RSP = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin winner selection: first valid requester found
// scanning upward from ptr, wrapping modulo NREQ.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req_val,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx,
  output logic            any
);

  int  j_s;
  logic hit_s;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant = {NREQ{1'b0}};
    idx   = 2'd0;
    any   = 1'b0;
    j_s   = 0;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j_s      = (int'(ptr) + k) % NREQ;
      hit_s    = !any && req_val[j_s];
      grant[j_s] = hit_s;
      idx      = hit_s ? 2'(j_s) : idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master transaction port among NREQ
// requesters: accept, forward, wait (with timeout), route the response back.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*MSG_W-1:0] req_msg,
  output logic                  mst_send_val,
  input  logic                  mst_send_rdy,
  output logic [MSG_W-1:0]      mst_send_msg,
  input  logic                  mst_recv_val,
  output logic                  mst_recv_rdy,
  input  logic [MSG_W-1:0]      mst_recv_msg,
  output logic [NREQ-1:0]       rsp_val,
  input  logic [NREQ-1:0]       rsp_rdy,
  output logic [MSG_W-1:0]      rsp_msg,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [MSG_W-1:0] ERR_MSG      = MSG_W'(ERR_RSP);

  arb_state_e       state_r, state_s;
  logic [MSG_W-1:0] buf_r, buf_s;
  logic [15:0]      cnt_r, cnt_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       gid_r, gid_s;
  logic             terr_s;

  // Output registers; idle_r gates the combinational req_rdy so that
  // every output reads 0 while reset is held.
  logic             idle_r;
  logic             send_val_r;
  logic             recv_rdy_r;
  logic             busy_r;
  logic             terr_r;
  logic [NREQ-1:0]  rsp_val_r;

  logic [NREQ-1:0]  pick_grant_s;
  logic [1:0]       pick_idx_s;
  logic             pick_any_s;
  logic [MSG_W-1:0] sel_msg_s;
  logic [NREQ-1:0]  gid_oh_s;
  logic             rsp_hit_s;

  spi_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_val (req_val),
    .ptr     (ptr_r),
    .grant   (pick_grant_s),
    .idx     (pick_idx_s),
    .any     (pick_any_s)
  );

  // AND-OR mux of the winning request and one-hot decode of the grantee.
  always_comb begin
    sel_msg_s = {MSG_W{1'b0}};
    gid_oh_s  = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_msg_s   = sel_msg_s | (req_msg[i*MSG_W +: MSG_W] & {MSG_W{pick_grant_s[i]}});
      gid_oh_s[i] = (gid_r == 2'(i));
    end
  end

  assign rsp_hit_s = |(rsp_rdy & gid_oh_s);

  // Next-state and datapath update for the IDLE/SEND/WAIT/RESP sequence.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    gid_s   = gid_r;
    terr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (idle_r && pick_any_s) begin
          buf_s   = sel_msg_s;
          gid_s   = pick_idx_s;
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (mst_send_rdy) begin
          cnt_s   = 16'd0;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r + 16'd1;
        // A real response beats a timeout landing in the same cycle.
        if (mst_recv_val) begin
          buf_s   = mst_recv_msg;
          state_s = ST_RESP;
        end else if (cnt_r == TIMEOUT_LAST) begin
          buf_s   = ERR_MSG;
          terr_s  = 1'b1;
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_hit_s) begin
          ptr_s   = (gid_r == 2'(NREQ - 1)) ? 2'd0 : gid_r + 2'd1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, buffer, counter, pointer and grant registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      buf_r   <= {MSG_W{1'b0}};
      cnt_r   <= 16'd0;
      ptr_r   <= 2'd0;
      gid_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      gid_r   <= gid_s;
    end
  end

  // Moore outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_r     <= 1'b0;
      send_val_r <= 1'b0;
      recv_rdy_r <= 1'b0;
      busy_r     <= 1'b0;
      terr_r     <= 1'b0;
      rsp_val_r  <= {NREQ{1'b0}};
    end else begin
      idle_r     <= (state_s == ST_IDLE);
      send_val_r <= (state_s == ST_SEND);
      recv_rdy_r <= (state_s == ST_IDLE) || (state_s == ST_WAIT);
      busy_r     <= (state_s != ST_IDLE);
      terr_r     <= terr_s;
      rsp_val_r  <= (state_s == ST_RESP) ? gid_oh_s : {NREQ{1'b0}};
    end
  end

  assign req_rdy      = idle_r ? pick_grant_s : {NREQ{1'b0}};
  assign mst_send_val = send_val_r;
  assign mst_send_msg = buf_r;
  assign mst_recv_rdy = recv_rdy_r;
  assign rsp_val      = rsp_val_r;
  assign rsp_msg      = buf_r;
  assign grant_id     = gid_r;
  assign busy         = busy_r;
  assign timeout_err  = terr_r;

endmodule
